profile_seq: RTL and testbench



---
 rtl/profile_seq_pkg.sv | 15 +
 rtl/profile_seq_ram.sv | 24 ++
 rtl/profile_seq.sv | 173 +++++++++++++++++
 tb/tb_profile_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/profile_seq_pkg.sv
// profile_seq shared types and widths.
// Optional build macro: PROFILE_SEQ_EXT_TRIG_EN.
package profile_seq_pkg;

  localparam int PROF_W      = 3;
  localparam int NCH         = 4;
  localparam int PROF_WORD_W = PROF_W * NCH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD
  } state_e;

endpackage

// File: rtl/profile_seq_ram.sv
// Profile table: one write port, one registered read port.
// Read-first on a same-address collision.
module profile_seq_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 28
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem_q[rd_addr];
  end

endmodule

// File: rtl/profile_seq.sv
// Table-driven DDS profile sequencer with clock-exact dwell.
// Optional build macro: PROFILE_SEQ_EXT_TRIG_EN adds ext_trig.
module profile_seq
  import profile_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [PROF_WORD_W-1:0] wr_prof,
  input  logic [CNT_W-1:0]       wr_dwell,
  input  logic [AW-1:0]          last_idx,
  input  logic                   loop_en,
  input  logic                   start,
  input  logic                   stop,
`ifdef PROFILE_SEQ_EXT_TRIG_EN
  input  logic                   ext_trig,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [PROF_W-1:0]      ch0_profile_ext,
  output logic [PROF_W-1:0]      ch1_profile_ext,
  output logic [PROF_W-1:0]      ch2_profile_ext,
  output logic [PROF_W-1:0]      ch3_profile_ext
);

  localparam int DW = PROF_WORD_W + CNT_W;

  state_e                 state_q;
  logic [AW-1:0]          idx_q, last_q;
  logic                   loop_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [PROF_WORD_W-1:0] prof_q;
  logic                   busy_q, done_q;

  logic                   rd_en;
  logic [AW-1:0]          rd_addr;
  logic [DW-1:0]          rd_data;
  logic [PROF_WORD_W-1:0] rd_prof;
  logic [CNT_W-1:0]       rd_dwell, dwell_ld;
  logic [AW-1:0]          nxt_idx, nxt2_idx;
  logic                   at_end, go;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] i,
    input logic [AW-1:0] last
  );
    return (i == last) ? '0 : i + 1'b1;
  endfunction

`ifdef PROFILE_SEQ_EXT_TRIG_EN
  logic [2:0] trig_q;
  logic       trig_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trig_q <= '0;
    else        trig_q <= {trig_q[1:0], ext_trig};
  end

  assign trig_rise = trig_q[1] & ~trig_q[2];
  assign go        = (start | trig_rise) & ~stop;
`else
  assign go = start & ~stop;
`endif

  assign rd_prof  = rd_data[PROF_WORD_W-1:0];
  assign rd_dwell = rd_data[DW-1:PROF_WORD_W];
  assign dwell_ld = (rd_dwell < CNT_W'(2)) ? CNT_W'(2) : rd_dwell;
  assign nxt_idx  = nxt(idx_q, last_q);
  assign nxt2_idx = nxt(nxt_idx, last_q);
  assign at_end   = (idx_q == last_q) && !loop_q;

  // Read port is only enabled when a fetch is issued so a prefetched
  // entry is immune to later table writes.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    unique case (state_q)
      S_IDLE: rd_en = go;
      S_LOAD: begin
        rd_en   = !stop;
        rd_addr = nxt_idx;
      end
      S_HOLD: begin
        rd_en   = !stop && (cnt_q == CNT_W'(1)) && !at_end;
        rd_addr = nxt2_idx;
      end
      default: rd_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      cnt_q   <= '0;
      prof_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (go) begin
            state_q <= S_LOAD;
            idx_q   <= '0;
            last_q  <= last_idx;
            loop_q  <= loop_en;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_HOLD;
            prof_q  <= rd_prof;
            cnt_q   <= dwell_ld;
          end
        end
        S_HOLD: begin
          if (stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_W'(1)) begin
            if (at_end) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              idx_q  <= nxt_idx;
              prof_q <= rd_prof;
              cnt_q  <= dwell_ld;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  profile_seq_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data ({wr_dwell, wr_prof}),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign busy            = busy_q;
  assign done            = done_q;
  assign ch0_profile_ext = prof_q[2:0];
  assign ch1_profile_ext = prof_q[5:3];
  assign ch2_profile_ext = prof_q[8:6];
  assign ch3_profile_ext = prof_q[11:9];

endmodule

// File: tb/tb_profile_seq.sv
// Scoreboard bench for profile_seq: per-cycle expected
// {profile, busy, done} samples queued from a table model.
module tb_profile_seq;

  typedef struct packed {
    logic [11:0] prof;
    logic        busy;
    logic        done;
  } smp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [11:0] wr_prof = '0;
  logic [15:0] wr_dwell = '0;
  logic [3:0]  last_idx = '0;
  logic        loop_en = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        busy, done;
  logic [2:0]  ch0, ch1, ch2, ch3;

  int checks = 0;
  int errors = 0;

  smp_t        q[$];
  logic [11:0] mprof [16];
  int          mdw   [16];
  logic [11:0] last_prof = '0;

  profile_seq dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_prof         (wr_prof),
    .wr_dwell        (wr_dwell),
    .last_idx        (last_idx),
    .loop_en         (loop_en),
    .start           (start),
    .stop            (stop),
    .busy            (busy),
    .done            (done),
    .ch0_profile_ext (ch0),
    .ch1_profile_ext (ch1),
    .ch2_profile_ext (ch2),
    .ch3_profile_ext (ch3)
  );

  always #5 clk = ~clk;

  function automatic smp_t obs();
    smp_t s;
    s.prof = {ch3, ch2, ch1, ch0};
    s.busy = busy;
    s.done = done;
    return s;
  endfunction

  task automatic chk(string tag, smp_t got, smp_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got prof=%h busy=%b done=%b exp prof=%h busy=%b done=%b",
             tag, got.prof, got.busy, got.done, exp.prof, exp.busy, exp.done);
    end
  endtask

  task automatic tick();
    smp_t e;
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("seq", obs(), e);
    end
  endtask

  task automatic wr(int a, logic [11:0] p, int d);
    wr_en    = 1'b1;
    wr_addr  = 4'(a);
    wr_prof  = p;
    wr_dwell = 16'(d);
    mprof[a] = p;
    mdw[a]   = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic push(logic [11:0] p, logic b, logic d);
    smp_t s;
    s.prof = p;
    s.busy = b;
    s.done = d;
    q.push_back(s);
  endtask

  // Expected samples, one per edge, starting at the edge that samples start
  task automatic gen(int last, bit loop, int stop_after);
    logic [11:0] cur;
    int n, idx, d;
    cur = last_prof;
    push(cur, 1'b1, 1'b0);
    n = 1;
    idx = 0;
    for (int g = 0; g < 64; g++) begin
      d = (mdw[idx] < 2) ? 2 : mdw[idx];
      for (int k = 0; k < d; k++) begin
        if (stop_after != 0 && n == stop_after) begin
          push(cur, 1'b0, 1'b0);
          push(cur, 1'b0, 1'b0);
          last_prof = cur;
          return;
        end
        cur = mprof[idx];
        push(cur, 1'b1, 1'b0);
        n++;
      end
      if (idx == last && !loop) begin
        if (stop_after != 0 && n == stop_after) push(cur, 1'b0, 1'b0);
        else                                    push(cur, 1'b0, 1'b1);
        push(cur, 1'b0, 1'b0);
        last_prof = cur;
        return;
      end
      idx = (idx == last) ? 0 : idx + 1;
    end
    last_prof = cur;
  endtask

  task automatic run(int last, bit loop, int stop_after);
    gen(last, loop, stop_after);
    last_idx = 4'(last);
    loop_en  = loop;
    start    = 1'b1;
    for (int i = 1; i <= 3000 && q.size() != 0; i++) begin
      tick();
      start = (i == 3);
      stop  = (stop_after != 0 && i == stop_after);
    end
    start = 1'b0;
    stop  = 1'b0;
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL timeout pending=%0d exp 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    smp_t zero;
    zero = '0;
    for (int i = 0; i < 16; i++) begin
      mprof[i] = '0;
      mdw[i]   = 0;
    end

    #12;
    chk("reset", obs(), zero);
    #10 rst_n = 1'b1;
    tick();
    chk("after_reset", obs(), zero);

    wr(0, 12'h001, 4);
    wr(1, 12'h0C2, 5);
    wr(2, 12'hFFF, 3);

    run(2, 1'b0, 0);
    run(2, 1'b1, 40);
    run(2, 1'b0, 7);

    start = 1'b1;
    stop  = 1'b1;
    push(last_prof, 1'b0, 1'b0);
    push(last_prof, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    stop  = 1'b0;
    tick();

    wr(0, 12'h123, 0);
    wr(1, 12'h456, 1);
    wr(2, 12'h789, 2);
    wr(3, 12'hABC, 7);
    run(3, 1'b0, 0);

    run(0, 1'b1, 9);

    wr(0, 12'h001, 4);
    wr(1, 12'h0C2, 5);
    wr(2, 12'hFFF, 3);
    last_idx = 4'd2;
    loop_en  = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_reset", obs(), zero);
    @(posedge clk);
    #1;
    chk("held_reset", obs(), zero);
    rst_n = 1'b1;
    last_prof = '0;
    tick();
    run(2, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
